// File: rtl/eth_frame_pkg.sv
// Shared types, constants and helper functions for the Ethernet II frame generator.
package eth_frame_pkg;

  typedef enum logic [3:0] {
    ST_IGP  = 4'd0,
    ST_PRE  = 4'd1,
    ST_SFD  = 4'd2,
    ST_DA   = 4'd3,
    ST_SA   = 4'd4,
    ST_LEN  = 4'd5,
    ST_DATA = 4'd6,
    ST_PAD  = 4'd7,
    ST_FCS  = 4'd8
  } state_t;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC32_POLY    = 32'h04C1_1DB7;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB_20E3;
  // Feedback taps 31, 30, 29, 27, 25 and 0 of the payload LFSR.
  localparam logic [31:0] LFSR_TAPS     = 32'hEA00_0001;

  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

  function automatic logic [31:0] lfsr_step8(input logic [31:0] v);
    logic [31:0] r;
    r = v;
    for (int i = 0; i < 8; i++) begin
      r = {r[30:0], ^(r & LFSR_TAPS)};
    end
    return r;
  endfunction

endpackage

// File: rtl/crc32_d8.sv
// Combinational byte-wide IEEE 802.3 CRC-32 update, reflected (LSB-first) form.
module crc32_d8
  import eth_frame_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [7:0]  data,
  output logic [31:0] crc_next
);

  localparam logic [31:0] POLY_REFL = reflect32(CRC32_POLY);

  // Eight shift-right steps over the byte folded into the low bits.
  always_comb begin
    logic [31:0] c;
    c = crc ^ {24'h00_0000, data};
    for (int i = 0; i < 8; i++) begin
      c = {1'b0, c[31:1]} ^ (c[0] ? POLY_REFL : 32'h0000_0000);
    end
    crc_next = c;
  end

endmodule

// File: rtl/eth_frame_gen.sv
// Ethernet II test-frame generator: preamble, SFD, addresses, length, LFSR payload,
// zero padding and FCS, streamed byte-by-byte over a valid/ready handshake.
module eth_frame_gen
  import eth_frame_pkg::*;
#(
  parameter int unsigned IFG_BYTES      = 12,
  parameter int unsigned PREAMBLE_BYTES = 7,
  parameter int unsigned MIN_DATA       = 46,
  parameter int unsigned MAX_DATA       = 1500,
  parameter int unsigned LEN_W          = 11,
  parameter logic [31:0] LFSR_SEED      = 32'hFFFF_FFFF,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             iclk,
  input  logic             irst_n,
  input  logic             ienable,
  input  logic [LEN_W-1:0] ilen,
  input  logic [47:0]      idaddr,
  input  logic [47:0]      isaddr,
  input  logic             iready,
  output logic [7:0]       odata_byte,
  output logic             ovalid,
  output logic             osof,
  output logic             oeof,
  output logic [3:0]       ost,
  output logic             olen_err,
  output logic [CNT_W-1:0] oframe_cnt
);

  localparam int unsigned   LW       = LEN_W + 1;
  localparam logic [LW-1:0] ONE      = LW'(1);
  localparam logic [LW-1:0] IFG_C    = LW'(IFG_BYTES);
  localparam logic [LW-1:0] PRE_LAST = LW'(PREAMBLE_BYTES - 1);
  localparam logic [LW-1:0] MIN_C    = LW'(MIN_DATA);
  localparam logic [LW-1:0] MAX_C    = LW'(MAX_DATA);

  state_t        state, nxt_state, succ;
  logic [LW-1:0] cnt, nxt_cnt, cnt_inc, len, nxt_len;
  logic [31:0]   lfsr, nxt_lfsr, crc, nxt_crc, crc_upd, fcs;
  logic [47:0]   da, nxt_da, sa, nxt_sa;
  logic [15:0]   len16;
  logic [7:0]    nxt_byte;
  logic          xfer, last, len_err, frame_done;

  assign xfer    = ovalid & iready;
  assign cnt_inc = cnt + ONE;

  crc32_d8 u_crc (
    .crc      (crc),
    .data     (odata_byte),
    .crc_next (crc_upd)
  );

  // Whether the current byte is the last of its field, and which field follows.
  always_comb begin
    case (state)
      ST_IGP:  begin last = 1'b0;                        succ = ST_IGP;  end
      ST_PRE:  begin last = (cnt == PRE_LAST);           succ = ST_SFD;  end
      ST_SFD:  begin last = 1'b1;                        succ = ST_DA;   end
      ST_DA:   begin last = (cnt == LW'(5));             succ = ST_SA;   end
      ST_SA:   begin last = (cnt == LW'(5));             succ = ST_LEN;  end
      ST_LEN:  begin last = (cnt == ONE);
                     succ = (len != '0) ? ST_DATA : ST_PAD;              end
      ST_DATA: begin last = (cnt == len - ONE);
                     succ = (len < MIN_C) ? ST_PAD : ST_FCS;             end
      // Only reached when len < MIN_C, so the subtraction cannot wrap.
      ST_PAD:  begin last = (cnt == MIN_C - len - ONE);  succ = ST_FCS;  end
      ST_FCS:  begin last = (cnt == LW'(3));             succ = ST_IGP;  end
      default: begin last = 1'b1;                        succ = ST_IGP;  end
    endcase
  end

  // Next-state and datapath update: frame start in IGP, advance on each transfer.
  always_comb begin
    nxt_state  = state;
    nxt_cnt    = cnt;
    nxt_len    = len;
    nxt_lfsr   = lfsr;
    nxt_crc    = crc;
    nxt_da     = da;
    nxt_sa     = sa;
    len_err    = 1'b0;
    frame_done = 1'b0;
    if (state == ST_IGP) begin
      if (ienable && (cnt_inc >= IFG_C)) begin
        nxt_state = ST_PRE;
        nxt_cnt   = '0;
        nxt_da    = idaddr;
        nxt_sa    = isaddr;
        len_err   = (LW'(ilen) > MAX_C);
        nxt_len   = len_err ? MAX_C : LW'(ilen);
        nxt_crc   = CRC32_INIT;
      end else if (cnt != IFG_C) begin
        nxt_cnt = cnt_inc;
      end else begin
        nxt_cnt = cnt;
      end
    end else if (xfer) begin
      if (state inside {ST_DA, ST_SA, ST_LEN, ST_DATA, ST_PAD}) begin
        nxt_crc = crc_upd;
      end else begin
        nxt_crc = crc;
      end
      if (state == ST_DATA) begin
        nxt_lfsr = lfsr_step8(lfsr);
      end else begin
        nxt_lfsr = lfsr;
      end
      if (last) begin
        nxt_state  = succ;
        nxt_cnt    = '0;
        frame_done = (state == ST_FCS);
      end else begin
        nxt_cnt = cnt_inc;
      end
    end else begin
      nxt_state = state;
    end
  end

  // Byte presented for the upcoming state, so the output register is ready with it.
  always_comb begin
    fcs   = ~nxt_crc;
    len16 = 16'(nxt_len);
    case (nxt_state)
      ST_PRE:  nxt_byte = PREAMBLE_BYTE;
      ST_SFD:  nxt_byte = SFD_BYTE;
      ST_DA:   nxt_byte = nxt_da[6'd40 - {nxt_cnt[2:0], 3'b000} +: 8];
      ST_SA:   nxt_byte = nxt_sa[6'd40 - {nxt_cnt[2:0], 3'b000} +: 8];
      ST_LEN:  nxt_byte = nxt_cnt[0] ? len16[7:0] : len16[15:8];
      ST_DATA: nxt_byte = nxt_lfsr[7:0];
      ST_FCS:  nxt_byte = fcs[{nxt_cnt[1:0], 3'b000} +: 8];
      default: nxt_byte = 8'h00;
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state      <= ST_IGP;
      cnt        <= '0;
      len        <= '0;
      lfsr       <= LFSR_SEED;
      crc        <= CRC32_INIT;
      da         <= 48'h0;
      sa         <= 48'h0;
      odata_byte <= 8'h00;
      ovalid     <= 1'b0;
      osof       <= 1'b0;
      oeof       <= 1'b0;
      ost        <= 4'h0;
      olen_err   <= 1'b0;
      oframe_cnt <= '0;
    end else begin
      state      <= nxt_state;
      cnt        <= nxt_cnt;
      len        <= nxt_len;
      lfsr       <= nxt_lfsr;
      crc        <= nxt_crc;
      da         <= nxt_da;
      sa         <= nxt_sa;
      odata_byte <= nxt_byte;
      ovalid     <= (nxt_state != ST_IGP);
      osof       <= (nxt_state == ST_PRE) && (nxt_cnt == '0);
      oeof       <= (nxt_state == ST_FCS) && (nxt_cnt == LW'(3));
      ost        <= nxt_state;
      olen_err   <= len_err;
      oframe_cnt <= oframe_cnt + CNT_W'(frame_done);
    end
  end

endmodule

// File: tb/tb_eth_frame_gen.sv
// Directed self-checking bench for eth_frame_gen with an independent frame/CRC/LFSR model.
module tb_eth_frame_gen;

  localparam logic [47:0] DA = 48'h0011_2233_4455;
  localparam logic [47:0] SA = 48'h6677_8899_AABB;

  logic        iclk, irst_n, ienable, iready;
  logic [10:0] ilen;
  logic [47:0] idaddr, isaddr;
  logic [7:0]  odata_byte;
  logic        ovalid, osof, oeof, olen_err;
  logic [3:0]  ost;
  logic [15:0] oframe_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]  got_q[$];
  logic [7:0]  exp_q[$];
  logic [7:0]  f1_q[$];
  logic [31:0] m_lfsr;
  int idle_n, sof_pos, eof_pos, stall_err, gap_err, lerr_n, timeout, cnt_first;

  eth_frame_gen dut (
    .iclk       (iclk),
    .irst_n     (irst_n),
    .ienable    (ienable),
    .ilen       (ilen),
    .idaddr     (idaddr),
    .isaddr     (isaddr),
    .iready     (iready),
    .odata_byte (odata_byte),
    .ovalid     (ovalid),
    .osof       (osof),
    .oeof       (oeof),
    .ost        (ost),
    .olen_err   (olen_err),
    .oframe_cnt (oframe_cnt)
  );

  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_checks++;
    if (obs === want) n_pass++;
    else $display("FAIL %s: observed %0h expected %0h", tag, obs, want);
  endtask

  function automatic logic [31:0] m_crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    logic fb;
    r = c;
    for (int k = 0; k < 8; k++) begin
      fb = r[0] ^ b[k];
      r  = r >> 1;
      if (fb) r = r ^ 32'hEDB8_8320;
    end
    return r;
  endfunction

  function automatic logic [31:0] m_lfsr_adv(input logic [31:0] v);
    logic [31:0] r;
    r = v;
    for (int k = 0; k < 8; k++) r = {r[30:0], r[31] ^ r[30] ^ r[29] ^ r[27] ^ r[25] ^ r[0]};
    return r;
  endfunction

  function automatic logic [7:0] gb(input int i);
    if (i < got_q.size()) return got_q[i];
    return 8'hEE;
  endfunction

  function automatic logic [31:0] got_residue();
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int k = 8; k < got_q.size(); k++) c = m_crc_byte(c, got_q[k]);
    return c;
  endfunction

  task automatic build_exp(input int req, input logic [47:0] da, input logic [47:0] sa);
    int          l;
    logic [15:0] l16;
    logic [31:0] c;
    exp_q.delete();
    l   = (req > 1500) ? 1500 : req;
    l16 = 16'(l);
    repeat (7) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    for (int k = 0; k < 6; k++) exp_q.push_back(da[47-8*k -: 8]);
    for (int k = 0; k < 6; k++) exp_q.push_back(sa[47-8*k -: 8]);
    exp_q.push_back(l16[15:8]);
    exp_q.push_back(l16[7:0]);
    for (int k = 0; k < l; k++) begin
      exp_q.push_back(m_lfsr[7:0]);
      m_lfsr = m_lfsr_adv(m_lfsr);
    end
    for (int k = l; k < 46; k++) exp_q.push_back(8'h00);
    c = 32'hFFFF_FFFF;
    for (int k = 8; k < exp_q.size(); k++) c = m_crc_byte(c, exp_q[k]);
    c = ~c;
    for (int k = 0; k < 4; k++) exp_q.push_back(c[8*k +: 8]);
  endtask

  task automatic compare_frame(input string tag);
    int mism;
    mism = 0;
    check_value({tag, " len"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++)
      if (got_q[k] !== exp_q[k]) mism++;
    check_value({tag, " bytes"}, 64'(mism), 64'd0);
  endtask

  task automatic capture_frame(input bit rnd);
    int         guard;
    bit         done, stalled;
    logic [7:0] held_d;
    logic [3:0] held_st;
    logic       held_sof, held_eof;
    got_q.delete();
    idle_n = 0; sof_pos = -1; eof_pos = -1; stall_err = 0; gap_err = 0; lerr_n = 0;
    timeout = 1; done = 1'b0; stalled = 1'b0;
    held_d = 8'h00; held_st = 4'h0; held_sof = 1'b0; held_eof = 1'b0;
    iready = 1'b1;
    @(negedge iclk);
    cnt_first = int'(oframe_cnt);
    guard = 0;
    while (!ovalid && guard < 4000) begin
      if (olen_err) lerr_n++;
      idle_n++;
      guard++;
      @(negedge iclk);
    end
    if (!ovalid) return;
    guard = 0;
    while (!done && guard < 20000) begin
      if (olen_err) lerr_n++;
      if (!ovalid) begin
        gap_err++;
        break;
      end
      if (stalled && (odata_byte !== held_d || ost !== held_st ||
                      osof !== held_sof || oeof !== held_eof)) stall_err++;
      iready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (iready) begin
        if (osof) sof_pos = got_q.size();
        if (oeof) begin
          eof_pos = got_q.size();
          done    = 1'b1;
        end
        got_q.push_back(odata_byte);
        stalled = 1'b0;
      end else begin
        stalled  = 1'b1;
        held_d   = odata_byte;
        held_st  = ost;
        held_sof = osof;
        held_eof = oeof;
      end
      guard++;
      if (!done) @(negedge iclk);
    end
    timeout = done ? 0 : 1;
    iready  = 1'b1;
  endtask

  initial begin
    int g, vseen, mism, zeros;
    irst_n = 1'b0; ienable = 1'b0; ilen = 11'd46; idaddr = DA; isaddr = SA; iready = 1'b1;
    m_lfsr = 32'hFFFF_FFFF;
    repeat (3) @(negedge iclk);
    check_value("rst ovalid", 64'(ovalid), 64'd0);
    check_value("rst data", 64'(odata_byte), 64'd0);
    check_value("rst ost", 64'(ost), 64'd0);
    check_value("rst frame_cnt", 64'(oframe_cnt), 64'd0);
    irst_n = 1'b1;
    ienable = 1'b1;

    // Minimum-size frame, always ready.
    build_exp(46, DA, SA);
    capture_frame(1'b0);
    check_value("f1 timeout", 64'(timeout), 64'd0);
    compare_frame("f1");
    check_value("f1 size", 64'(got_q.size()), 64'd72);
    check_value("f1 sof pos", 64'(sof_pos), 64'd0);
    check_value("f1 eof pos", 64'(eof_pos), 64'd71);
    check_value("f1 len hi", 64'(gb(20)), 64'h00);
    check_value("f1 len lo", 64'(gb(21)), 64'h2E);
    check_value("f1 first payload", 64'(gb(22)), 64'hFF);
    check_value("f1 residue", 64'(got_residue()), 64'hDEBB_20E3);
    check_value("f1 len_err", 64'(lerr_n), 64'd0);
    check_value("f1 frame_cnt", 64'(cnt_first), 64'd0);
    f1_q = got_q;

    // Short payload with padding.
    ilen = 11'd10;
    build_exp(10, DA, SA);
    capture_frame(1'b0);
    check_value("f2 idle", 64'(idle_n), 64'd12);
    compare_frame("f2");
    check_value("f2 size", 64'(got_q.size()), 64'd72);
    check_value("f2 len lo", 64'(gb(21)), 64'h0A);
    zeros = 0;
    for (int k = 32; k < 68; k++) if (gb(k) == 8'h00) zeros++;
    check_value("f2 pad zeros", 64'(zeros), 64'd36);
    check_value("f2 residue", 64'(got_residue()), 64'hDEBB_20E3);
    check_value("f2 frame_cnt", 64'(cnt_first), 64'd1);

    // Oversize request is clamped.
    ilen = 11'd1600;
    build_exp(1600, DA, SA);
    capture_frame(1'b0);
    compare_frame("f3");
    check_value("f3 size", 64'(got_q.size()), 64'd1526);
    check_value("f3 len hi", 64'(gb(20)), 64'h05);
    check_value("f3 len lo", 64'(gb(21)), 64'hDC);
    check_value("f3 len_err", 64'(lerr_n), 64'd1);
    check_value("f3 eof pos", 64'(eof_pos), 64'd1525);

    // ienable drops while the payload is being sent.
    ilen = 11'd46;
    fork
      begin
        int w;
        w = 0;
        @(negedge iclk);
        while (ost != 4'd6 && w < 3000) begin
          @(negedge iclk);
          w++;
        end
        ienable = 1'b0;
      end
    join_none
    build_exp(46, DA, SA);
    capture_frame(1'b0);
    compare_frame("f4");
    check_value("f4 residue", 64'(got_residue()), 64'hDEBB_20E3);
    vseen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge iclk);
      if (k == 0) check_value("f4 frame_cnt", 64'(oframe_cnt), 64'd4);
      if (ovalid) vseen++;
    end
    check_value("f4 idle after", 64'(vseen), 64'd0);

    // Reset in the middle of the payload.
    ienable = 1'b1;
    g = 0;
    while (ost != 4'd6 && g < 500) begin
      @(negedge iclk);
      g++;
    end
    check_value("f5 reached data", 64'(ost), 64'd6);
    repeat (3) @(negedge iclk);
    irst_n = 1'b0;
    #1;
    check_value("mid rst ovalid", 64'(ovalid), 64'd0);
    check_value("mid rst data", 64'(odata_byte), 64'd0);
    check_value("mid rst ost", 64'(ost), 64'd0);
    check_value("mid rst frame_cnt", 64'(oframe_cnt), 64'd0);
    @(negedge iclk);
    irst_n = 1'b1;
    m_lfsr = 32'hFFFF_FFFF;

    // Same frame as the first, now with a random ready pattern.
    build_exp(46, DA, SA);
    capture_frame(1'b1);
    check_value("f5 timeout", 64'(timeout), 64'd0);
    compare_frame("f5");
    mism = 0;
    for (int k = 0; k < f1_q.size(); k++) if (gb(k) !== f1_q[k]) mism++;
    check_value("f5 vs f1", 64'(mism), 64'd0);
    check_value("f5 first payload", 64'(gb(22)), 64'hFF);
    check_value("f5 stall hold", 64'(stall_err), 64'd0);
    check_value("f5 gaps", 64'(gap_err), 64'd0);
    check_value("f5 sof pos", 64'(sof_pos), 64'd0);
    check_value("f5 eof pos", 64'(eof_pos), 64'd71);
    check_value("f5 frame_cnt", 64'(cnt_first), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
